// File: rtl/vga_marquee_ctrl_if.sv
// vga_marquee_ctrl_if: host write port into the marquee message RAM
interface vga_marquee_ctrl_if #(
   parameter int AW = 5
) ();
   logic          valid;
   logic          ready;
   logic [AW-1:0] addr;
   logic [7:0]    data;
   modport master (output valid, addr, data, input ready);
   modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/vga_marquee_ctrl.sv
// vga_marquee_ctrl: frame-synchronous right-to-left glyph scroller fed from a host-written message RAM
module vga_marquee_ctrl #(
   parameter int MSG_DEPTH = 32,
   parameter int AW        = 5,
   parameter int SCREEN_W  = 800,
   parameter int FRAME_DIV = 2,
   parameter int STEP      = 4
) (
   input  logic              px_clk,
   input  logic              rst,
   input  logic [25:0]       strRGB_i,
   input  logic              run,
   input  logic [AW:0]       msg_len,
   input  logic [9:0]        y_cfg,
   input  logic [2:0]        color_cfg,
   input  logic [2:0]        zoom_cfg,
   vga_marquee_ctrl_if.slave wr,
   output logic [7:0]        character,
   output logic [9:0]        x_pos,
   output logic [9:0]        y_pos,
   output logic [2:0]        color,
   output logic [2:0]        zoom,
   output logic              busy,
   output logic              wrap_pulse
);
   localparam int FW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
   localparam logic [9:0] X_RELOAD = 10'(SCREEN_W);
   localparam logic [9:0] X_STEP = 10'(STEP);
   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_STEP, S_FETCH, S_LOAD} state_t;
   state_t        state, state_nx;
   logic          vs_d, tick, frame_last;
   logic [FW-1:0] frame_cnt;
   logic [AW-1:0] idx, idx_nx;
   logic [AW:0]   eff_len, idx_inc;
   logic [7:0]    mem [MSG_DEPTH];
   logic [7:0]    rd_data;
   logic          unused_rgb;
   assign tick       = strRGB_i[1] & ~vs_d;
   assign unused_rgb = ^{strRGB_i[25:2], strRGB_i[0]};
   assign frame_last = frame_cnt == FW'(FRAME_DIV - 1);
   assign busy       = state != S_IDLE;
   assign wr.ready   = state != S_FETCH;
   assign eff_len    = msg_len == '0 ? (AW+1)'(1) : msg_len > (AW+1)'(MSG_DEPTH) ? (AW+1)'(MSG_DEPTH) : msg_len;
   assign idx_inc    = {1'b0, idx} + (AW+1)'(1);
   assign idx_nx     = idx_inc >= eff_len ? '0 : idx_inc[AW-1:0];
   // state register
   always_ff @(posedge px_clk or posedge rst)
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   // next state: run low parks in IDLE; WAIT leaves only on the FRAME_DIV-th frame tick
   always_comb begin
      state_nx = state;
      if (!run) state_nx = S_IDLE;
      else case (state)
         S_IDLE:  state_nx = S_START;
         S_START: state_nx = S_FETCH;
         S_WAIT:  state_nx = tick && frame_last ? S_STEP : S_WAIT;
         S_STEP:  state_nx = x_pos >= X_STEP ? S_WAIT : S_FETCH;
         S_FETCH: state_nx = S_LOAD;
         default: state_nx = S_WAIT;
      endcase
   end
   // datapath: frame divider, glyph position/attributes, message index and wrap strobe
   always_ff @(posedge px_clk or posedge rst)
      if (rst) begin
         vs_d       <= 1'b0;
         frame_cnt  <= '0;
         idx        <= '0;
         character  <= 8'h20;
         x_pos      <= X_RELOAD;
         y_pos      <= '0;
         color      <= '0;
         zoom       <= '0;
         wrap_pulse <= 1'b0;
      end else begin
         vs_d       <= strRGB_i[1];
         wrap_pulse <= 1'b0;
         if (!run) x_pos <= X_RELOAD;
         else case (state)
            S_START: begin
               idx       <= '0;
               frame_cnt <= '0;
               y_pos     <= y_cfg;
               color     <= color_cfg;
               zoom      <= zoom_cfg;
               x_pos     <= X_RELOAD;
            end
            S_WAIT: if (tick) frame_cnt <= frame_last ? '0 : frame_cnt + FW'(1);
            S_STEP: begin
               y_pos <= y_cfg;
               color <= color_cfg;
               zoom  <= zoom_cfg;
               if (x_pos >= X_STEP) x_pos <= x_pos - X_STEP;
               else begin
                  idx        <= idx_nx;
                  wrap_pulse <= idx_nx == '0;
                  x_pos      <= X_RELOAD;
               end
            end
            S_LOAD:  character <= rd_data;
            default: ;
         endcase
      end
   // message RAM: host write port, synchronous read launched in FETCH
   always_ff @(posedge px_clk) begin
      if (wr.valid && wr.ready) mem[wr.addr] <= wr.data;
      if (state == S_FETCH) rd_data <= mem[idx];
   end
endmodule

// File: tb/tb_vga_marquee_ctrl.sv
// tb_vga_marquee_ctrl: randomized directed bench against a frame-level scroll model
module tb_vga_marquee_ctrl;
   localparam int SW = 800, FD = 2, ST = 4;
   logic        px_clk = 1'b0;
   logic        rst;
   logic [25:0] rgb;
   logic        run;
   logic [5:0]  msg_len;
   logic [9:0]  y_cfg;
   logic [2:0]  color_cfg, zoom_cfg;
   logic [7:0]  character;
   logic [9:0]  x_pos, y_pos;
   logic [2:0]  color, zoom;
   logic        busy, wrap_pulse;
   int          checks = 0, errors = 0, wraps = 0;
   int          m_x, m_idx, m_fc;
   logic [7:0]  m_char;
   logic [9:0]  m_y;
   logic [2:0]  m_col, m_zoom;
   logic [7:0]  ram [32];

   always #5 px_clk = ~px_clk;

   vga_marquee_ctrl_if #(.AW(5)) wr_if ();

   vga_marquee_ctrl #(.MSG_DEPTH(32), .AW(5), .SCREEN_W(SW), .FRAME_DIV(FD), .STEP(ST)) dut (
      .px_clk(px_clk), .rst(rst), .strRGB_i(rgb), .run(run), .msg_len(msg_len),
      .y_cfg(y_cfg), .color_cfg(color_cfg), .zoom_cfg(zoom_cfg), .wr(wr_if),
      .character(character), .x_pos(x_pos), .y_pos(y_pos), .color(color), .zoom(zoom),
      .busy(busy), .wrap_pulse(wrap_pulse)
   );

   always @(negedge px_clk) if (wrap_pulse === 1'b1) wraps++;

   function automatic int eff(input int l);
      return l == 0 ? 1 : (l > 32 ? 32 : l);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [4:0] a, input logic [7:0] d);
      bit done;
      done = 1'b0;
      wr_if.valid = 1'b1;
      wr_if.addr  = a;
      wr_if.data  = d;
      for (int i = 0; i < 8 && !done; i++) begin
         done = wr_if.ready;
         @(negedge px_clk);
      end
      wr_if.valid = 1'b0;
      chk("wr_accept", 32'(done), 1);
      ram[a] = d;
   endtask

   task automatic start_run();
      run = 1'b1;
      m_idx = 0; m_fc = 0; m_x = SW; m_char = ram[0];
      m_y = y_cfg; m_col = color_cfg; m_zoom = zoom_cfg;
      repeat (4) @(negedge px_clk);
      chk("start_char", 32'(character), 32'(m_char));
      chk("start_x", 32'(x_pos), m_x);
      chk("start_y", 32'(y_pos), 32'(m_y));
      chk("start_color", 32'(color), 32'(m_col));
      chk("start_zoom", 32'(zoom), 32'(m_zoom));
      chk("start_busy", 32'(busy), 1);
   endtask

   task automatic do_frame(input bit wr_load, output bit exit);
      int ox, w0;
      logic [7:0] oc, d;
      bit wrapx, wr;
      ox = m_x; oc = m_char; w0 = wraps; wrapx = 0; wr = 0; exit = 0; d = 8'h00;
      y_cfg = 10'($urandom); color_cfg = 3'($urandom); zoom_cfg = 3'($urandom);
      m_fc++;
      if (m_fc == FD) begin
         m_fc = 0; m_y = y_cfg; m_col = color_cfg; m_zoom = zoom_cfg;
         if (m_x >= ST) m_x -= ST;
         else begin
            exit = 1;
            m_idx = (m_idx + 1 >= eff(int'(msg_len))) ? 0 : m_idx + 1;
            wrapx = m_idx == 0;
            m_x = SW;
            m_char = ram[m_idx];
         end
      end
      rgb = 26'($urandom) | 26'h2;
      @(negedge px_clk);
      chk("x_early", 32'(x_pos), ox);
      chk("busy_run", 32'(busy), 1);
      @(negedge px_clk);
      chk("x_step", 32'(x_pos), m_x);
      chk("y_step", 32'(y_pos), 32'(m_y));
      chk("color_step", 32'(color), 32'(m_col));
      chk("zoom_step", 32'(zoom), 32'(m_zoom));
      if (exit) begin
         chk("ready_fetch", 32'(wr_if.ready), 0);
         if (wr_load) begin
            wr = 1; d = ~ram[m_idx];
            wr_if.valid = 1'b1; wr_if.addr = 5'(m_idx); wr_if.data = d;
         end
      end
      @(negedge px_clk);
      chk("char_early", 32'(character), 32'(oc));
      if (exit) chk("ready_load", 32'(wr_if.ready), 1);
      @(negedge px_clk);
      chk("char_load", 32'(character), 32'(m_char));
      if (wr) begin
         wr_if.valid = 1'b0;
         ram[m_idx] = d;
      end
      repeat (2) @(negedge px_clk);
      rgb = 26'($urandom) & ~26'h2;
      repeat (4) @(negedge px_clk);
      chk("wrap_count", 32'(wraps - w0), 32'(wrapx));
   endtask

   task automatic run_exits(input int n, input bit wl);
      int got;
      bit ex;
      got = 0;
      for (int f = 0; f < 1000 && got < n; f++) begin
         do_frame(wl, ex);
         got += int'(ex);
      end
      chk("exit_budget", got, n);
   endtask

   task automatic run_frames(input int n);
      bit ex;
      for (int f = 0; f < n; f++) do_frame(1'b0, ex);
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; rgb = '0; msg_len = '0;
      y_cfg = '0; color_cfg = '0; zoom_cfg = '0;
      wr_if.valid = 1'b0; wr_if.addr = '0; wr_if.data = '0;
      repeat (2) @(negedge px_clk);
      chk("rst_char", 32'(character), 32'h20);
      chk("rst_x", 32'(x_pos), SW);
      chk("rst_y", 32'(y_pos), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(wr_if.ready), 1);
      rst = 1'b0;
      @(negedge px_clk);
      chk("idle_busy", 32'(busy), 0);
      for (int a = 0; a < 32; a++)
         write_word(5'(a), a == 0 ? 8'h41 : a == 1 ? 8'h42 : 8'($urandom));
      msg_len = 6'd2;
      y_cfg = 10'($urandom); color_cfg = 3'($urandom); zoom_cfg = 3'($urandom);
      start_run();
      run_exits(2, 1'b0);
      run_exits(1, 1'b1);
      run_exits(2, 1'b0);
      msg_len = 6'd1;
      run_exits(1, 1'b0);
      msg_len = 6'd0;
      run_exits(2, 1'b0);
      msg_len = 6'd2;
      run_frames(12);
      write_word(5'd0, 8'h5A);
      run = 1'b0;
      @(negedge px_clk);
      chk("drop_busy", 32'(busy), 0);
      chk("drop_x", 32'(x_pos), SW);
      chk("drop_char", 32'(character), 32'(m_char));
      start_run();
      run_frames(6);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_char", 32'(character), 32'h20);
      chk("mid_rst_x", 32'(x_pos), SW);
      chk("mid_rst_y", 32'(y_pos), 0);
      chk("mid_rst_color", 32'(color), 0);
      chk("mid_rst_zoom", 32'(zoom), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_wrap", 32'(wrap_pulse), 0);
      chk("mid_rst_ready", 32'(wr_if.ready), 1);
      @(negedge px_clk);
      run = 1'b0;
      rst = 1'b0;
      @(negedge px_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
